// File: rtl/alu_pkg.sv
// Shared types for the pipelined integer ALU: opcode enum, CR bit positions,
// E1 control payload and the CR-from-result helper.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUBF = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_CMP  = 4'd6,
        ALU_CMPL = 4'd7,
        ALU_SLW  = 4'd8,
        ALU_SRW  = 4'd9,
        ALU_SRAW = 4'd10,
        ALU_ROTL = 4'd11
    } alu_op_e;

    localparam int CR_LT = 2;
    localparam int CR_GT = 1;
    localparam int CR_EQ = 0;

    typedef struct packed {
        alu_op_e op;
        logic    cin;
    } e1_ctrl_t;

    function automatic logic [2:0] cr_of(input logic neg, input logic zero);
        logic [2:0] r;
        r        = 3'b000;
        r[CR_LT] = neg;
        r[CR_GT] = ~neg & ~zero;
        r[CR_EQ] = zero;
        return r;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath between the E1 and E2 registers.
// Shift/rotate opcodes exist only when ALU_SHIFT_EN is defined.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             cin,
    output logic [WIDTH-1:0] res,
    output logic [2:0]       cr,
    output logic             ca,
    output logic             ov
);

    localparam int MSB = WIDTH - 1;

    logic             sub_s;
    logic [WIDTH-1:0] a_eff_s;
    logic             c0_s;
    logic [WIDTH:0]   sum_s;
    logic             c_msb_s;
    logic             cr_from_res_s;
    logic [2:0]       cmp_cr_s;
    logic             lt_s;
    logic             eq_s;

`ifdef ALU_SHIFT_EN
    localparam int SH_W = $clog2(WIDTH) + 1;

    logic [SH_W-1:0]    amt_s;
    logic               big_s;
    logic [2*WIDTH-1:0] rot_s;
    logic [WIDTH-1:0]   slw_s;
    logic [WIDTH-1:0]   srw_s;
    logic [WIDTH-1:0]   sraw_s;
    logic [WIDTH-1:0]   rotl_s;
    logic [WIDTH-1:0]   lost_mask_s;
    logic               sraw_ca_s;

    // Shifter: amounts of WIDTH or more saturate; rotate uses amount mod WIDTH.
    always_comb begin
        amt_s  = src2[SH_W-1:0];
        big_s  = (amt_s >= SH_W'(WIDTH));
        rot_s  = {src1, src1} << amt_s[SH_W-2:0];
        rotl_s = rot_s[2*WIDTH-1:WIDTH];
        if (big_s) begin
            slw_s       = {WIDTH{1'b0}};
            srw_s       = {WIDTH{1'b0}};
            sraw_s      = {WIDTH{src1[MSB]}};
            lost_mask_s = {WIDTH{1'b1}};
        end else begin
            slw_s       = src1 << amt_s;
            srw_s       = src1 >> amt_s;
            sraw_s      = $signed(src1) >>> amt_s;
            lost_mask_s = ~({WIDTH{1'b1}} << amt_s);
        end
        sraw_ca_s = src1[MSB] & (|(src1 & lost_mask_s));
    end
`endif

    // Adder shared by ADD and SUBF, then per-opcode result/flag selection.
    always_comb begin
        sub_s   = (op == ALU_SUBF);
        a_eff_s = sub_s ? ~src1 : src1;
        c0_s    = sub_s ? 1'b1 : ((op == ALU_ADD) ? cin : 1'b0);
        sum_s   = {1'b0, a_eff_s} + {1'b0, src2} + {{WIDTH{1'b0}}, c0_s};
        c_msb_s = a_eff_s[MSB] ^ src2[MSB] ^ sum_s[MSB];
        eq_s    = (src1 == src2);
        lt_s    = 1'b0;

        res           = {WIDTH{1'b0}};
        ca            = 1'b0;
        ov            = 1'b0;
        cr_from_res_s = 1'b0;
        cmp_cr_s      = 3'b001;

        case (op)
            ALU_ADD, ALU_SUBF: begin
                res           = sum_s[MSB:0];
                ca            = sum_s[WIDTH];
                ov            = c_msb_s ^ sum_s[WIDTH];
                cr_from_res_s = 1'b1;
            end
            ALU_AND: begin
                res           = src1 & src2;
                cr_from_res_s = 1'b1;
            end
            ALU_OR: begin
                res           = src1 | src2;
                cr_from_res_s = 1'b1;
            end
            ALU_XOR: begin
                res           = src1 ^ src2;
                cr_from_res_s = 1'b1;
            end
            ALU_NOR: begin
                res           = ~(src1 | src2);
                cr_from_res_s = 1'b1;
            end
            ALU_CMP: begin
                lt_s     = ($signed(src1) < $signed(src2));
                cmp_cr_s = cr_of(lt_s, eq_s);
            end
            ALU_CMPL: begin
                lt_s     = (src1 < src2);
                cmp_cr_s = cr_of(lt_s, eq_s);
            end
`ifdef ALU_SHIFT_EN
            ALU_SLW: begin
                res           = slw_s;
                cr_from_res_s = 1'b1;
            end
            ALU_SRW: begin
                res           = srw_s;
                cr_from_res_s = 1'b1;
            end
            ALU_SRAW: begin
                res           = sraw_s;
                ca            = sraw_ca_s;
                cr_from_res_s = 1'b1;
            end
            ALU_ROTL: begin
                res           = rotl_s;
                cr_from_res_s = 1'b1;
            end
`else
            ALU_SLW, ALU_SRW, ALU_SRAW, ALU_ROTL: begin
                res      = {WIDTH{1'b0}};
                cmp_cr_s = 3'b001;
            end
`endif
            default: begin
                res      = {WIDTH{1'b0}};
                cmp_cr_s = 3'b001;
            end
        endcase

        if (cr_from_res_s) begin
            cr = cr_of(res[MSB], res == {WIDTH{1'b0}});
        end else begin
            cr = cmp_cr_s;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU (E1 operand latch, E2 result latch) with valid/ready
// handshake and flush. Optional shift ops are enabled by defining ALU_SHIFT_EN.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    input  logic             in_cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_cr,
    output logic             out_ca,
    output logic             out_ov,
    output logic [TAG_W-1:0] out_tag
);

    logic             e1_valid_q, e1_valid_d;
    e1_ctrl_t         e1_ctrl_q,  e1_ctrl_d;
    logic [WIDTH-1:0] e1_src1_q,  e1_src1_d;
    logic [WIDTH-1:0] e1_src2_q,  e1_src2_d;
    logic [TAG_W-1:0] e1_tag_q,   e1_tag_d;

    logic             e2_valid_q, e2_valid_d;
    logic [WIDTH-1:0] res_q,      res_d;
    logic [2:0]       cr_q,       cr_d;
    logic             ca_q,       ca_d;
    logic             ov_q,       ov_d;
    logic [TAG_W-1:0] tag_q,      tag_d;

    logic             e2_adv_s;
    logic             e1_adv_s;
    logic             in_ready_s;
    logic [WIDTH-1:0] core_res_s;
    logic [2:0]       core_cr_s;
    logic             core_ca_s;
    logic             core_ov_s;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op   (e1_ctrl_q.op),
        .src1 (e1_src1_q),
        .src2 (e1_src2_q),
        .cin  (e1_ctrl_q.cin),
        .res  (core_res_s),
        .cr   (core_cr_s),
        .ca   (core_ca_s),
        .ov   (core_ov_s)
    );

    // Handshake and next-state; flush overrides every transfer this cycle.
    always_comb begin
        e2_adv_s   = ~e2_valid_q | out_ready;
        e1_adv_s   = e1_valid_q & e2_adv_s;
        in_ready_s = ~e1_valid_q | e2_adv_s;

        e1_valid_d = e1_valid_q;
        e1_ctrl_d  = e1_ctrl_q;
        e1_src1_d  = e1_src1_q;
        e1_src2_d  = e1_src2_q;
        e1_tag_d   = e1_tag_q;
        e2_valid_d = e2_valid_q;
        res_d      = res_q;
        cr_d       = cr_q;
        ca_d       = ca_q;
        ov_d       = ov_q;
        tag_d      = tag_q;

        if (flush) begin
            e1_valid_d = 1'b0;
            e2_valid_d = 1'b0;
        end else begin
            if (in_valid && in_ready_s) begin
                e1_valid_d = 1'b1;
                e1_ctrl_d  = '{op: alu_op_e'(in_op), cin: in_cin};
                e1_src1_d  = in_src1;
                e1_src2_d  = in_src2;
                e1_tag_d   = in_tag;
            end else if (e1_adv_s) begin
                e1_valid_d = 1'b0;
            end else begin
                e1_valid_d = e1_valid_q;
            end

            if (e2_adv_s) begin
                e2_valid_d = e1_valid_q;
                if (e1_valid_q) begin
                    res_d = core_res_s;
                    cr_d  = core_cr_s;
                    ca_d  = core_ca_s;
                    ov_d  = core_ov_s;
                    tag_d = e1_tag_q;
                end else begin
                    res_d = res_q;
                end
            end else begin
                e2_valid_d = e2_valid_q;
            end
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e1_valid_q <= 1'b0;
            e1_ctrl_q  <= '{op: ALU_ADD, cin: 1'b0};
            e1_src1_q  <= {WIDTH{1'b0}};
            e1_src2_q  <= {WIDTH{1'b0}};
            e1_tag_q   <= {TAG_W{1'b0}};
            e2_valid_q <= 1'b0;
            res_q      <= {WIDTH{1'b0}};
            cr_q       <= 3'b000;
            ca_q       <= 1'b0;
            ov_q       <= 1'b0;
            tag_q      <= {TAG_W{1'b0}};
        end else begin
            e1_valid_q <= e1_valid_d;
            e1_ctrl_q  <= e1_ctrl_d;
            e1_src1_q  <= e1_src1_d;
            e1_src2_q  <= e1_src2_d;
            e1_tag_q   <= e1_tag_d;
            e2_valid_q <= e2_valid_d;
            res_q      <= res_d;
            cr_q       <= cr_d;
            ca_q       <= ca_d;
            ov_q       <= ov_d;
            tag_q      <= tag_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = e2_valid_q;
    assign out_result = res_q;
    assign out_cr     = cr_q;
    assign out_ca     = ca_q;
    assign out_ov     = ov_q;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=32): directed vectors push expected
// results; a negedge monitor pops and compares on every output transfer.
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic        in_cin;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_cr;
    logic        out_ca;
    logic        out_ov;
    logic [4:0]  out_tag;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  cr;
        logic        ca;
        logic        ov;
        logic [4:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    alu_pipe #(.WIDTH(32), .TAG_W(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_cin     (in_cin),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cr     (out_cr),
        .out_ca     (out_ca),
        .out_ov     (out_ov),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: the transfer happens at the next posedge when valid&ready here.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got tag %0d res 0x%0h, expected no output",
                         out_tag, out_result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_result !== e.res || out_cr !== e.cr || out_ca !== e.ca ||
                    out_ov !== e.ov || out_tag !== e.tag) begin
                    errors++;
                    $display("FAIL result_tag%0d: got res=0x%08h cr=%03b ca=%0b ov=%0b tag=%0d expected res=0x%08h cr=%03b ca=%0b ov=%0b tag=%0d",
                             e.tag, out_result, out_cr, out_ca, out_ov, out_tag,
                             e.res, e.cr, e.ca, e.ov, e.tag);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [4:0] tag,
                        input logic [31:0] er, input logic [2:0] ecr,
                        input logic eca, input logic eov, input bit push);
        bit accepted;
        int n;
        exp_t e;
        accepted = 1'b0;
        n        = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_cin   = cin;
        in_tag   = tag;
        while (!accepted && n < 100) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                if (push) begin
                    e.res = er; e.cr = ecr; e.ca = eca; e.ov = eov; e.tag = tag;
                    exp_q.push_back(e);
                end
            end
            n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: tag %0d got in_ready=0 for 100 cycles, expected 1", tag);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 4'd0;
        in_src1   = 32'd0;
        in_src2   = 32'd0;
        in_cin    = 1'b0;
        in_tag    = 5'd0;
        out_ready = 1'b1;
        #2;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_outputs", {out_result, 21'd0, out_cr, out_ca, out_ov, out_tag}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: overflow add, with a latency check
        send(ALU_ADD, 32'h7FFFFFFF, 32'h1, 1'b0, 5'd1, 32'h80000000, 3'b100, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("latency_e1_not_out", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("latency_two_cycles", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        // Main function, back-to-back at full rate
        send(ALU_ADD,  32'hFFFFFFFF, 32'h0,        1'b1, 5'd2,  32'h0,        3'b001, 1'b1, 1'b0, 1'b1);
        send(ALU_ADD,  32'h1,        32'h2,        1'b1, 5'd3,  32'h4,        3'b010, 1'b0, 1'b0, 1'b1);
        send(ALU_SUBF, 32'h5,        32'h3,        1'b0, 5'd4,  32'hFFFFFFFE, 3'b100, 1'b0, 1'b0, 1'b1);
        send(ALU_SUBF, 32'h3,        32'h5,        1'b0, 5'd5,  32'h2,        3'b010, 1'b1, 1'b0, 1'b1);
        send(ALU_SUBF, 32'h1,        32'h80000000, 1'b0, 5'd6,  32'h7FFFFFFF, 3'b010, 1'b1, 1'b1, 1'b1);
        send(ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'd7,  32'hF000F000, 3'b100, 1'b0, 1'b0, 1'b1);
        send(ALU_OR,   32'h0,        32'h0,        1'b0, 5'd8,  32'h0,        3'b001, 1'b0, 1'b0, 1'b1);
        send(ALU_XOR,  32'h0F0F0F0F, 32'h00FF00FF, 1'b0, 5'd9,  32'h0FF00FF0, 3'b010, 1'b0, 1'b0, 1'b1);
        send(ALU_NOR,  32'h0,        32'h0,        1'b0, 5'd10, 32'hFFFFFFFF, 3'b100, 1'b0, 1'b0, 1'b1);
        send(ALU_CMP,  32'hFFFFFFFF, 32'h1,        1'b0, 5'd11, 32'h0,        3'b100, 1'b0, 1'b0, 1'b1);
        send(ALU_CMPL, 32'hFFFFFFFF, 32'h1,        1'b0, 5'd12, 32'h0,        3'b010, 1'b0, 1'b0, 1'b1);
        send(ALU_CMP,  32'h5,        32'h5,        1'b0, 5'd13, 32'h0,        3'b001, 1'b0, 1'b0, 1'b1);
        send(ALU_CMPL, 32'h7,        32'h7,        1'b0, 5'd14, 32'h0,        3'b001, 1'b0, 1'b0, 1'b1);
        send(4'hF,     32'h12345678, 32'h9,        1'b1, 5'd15, 32'h0,        3'b001, 1'b0, 1'b0, 1'b1);
`ifdef ALU_SHIFT_EN
        send(ALU_SRAW, 32'h80000001, 32'd1,  1'b0, 5'd16, 32'hC0000000, 3'b100, 1'b1, 1'b0, 1'b1);
        send(ALU_SLW,  32'h00000001, 32'd32, 1'b0, 5'd17, 32'h0,        3'b001, 1'b0, 1'b0, 1'b1);
        send(ALU_SRW,  32'h80000000, 32'd31, 1'b0, 5'd18, 32'h1,        3'b010, 1'b0, 1'b0, 1'b1);
        send(ALU_ROTL, 32'h80000001, 32'd33, 1'b0, 5'd19, 32'h3,        3'b010, 1'b0, 1'b0, 1'b1);
        send(ALU_SRAW, 32'h80000000, 32'd40, 1'b0, 5'd20, 32'hFFFFFFFF, 3'b100, 1'b1, 1'b0, 1'b1);
`else
        send(ALU_SLW,  32'h00000001, 32'd1,  1'b0, 5'd16, 32'h0, 3'b001, 1'b0, 1'b0, 1'b1);
        send(ALU_SRAW, 32'h80000001, 32'd1,  1'b0, 5'd17, 32'h0, 3'b001, 1'b0, 1'b0, 1'b1);
`endif
        drain();

        // Test 4: backpressure, tags stay in order
        out_ready = 1'b0;
        send(ALU_ADD, 32'd10, 32'd1, 1'b0, 5'd1, 32'd11, 3'b010, 1'b0, 1'b0, 1'b1);
        send(ALU_ADD, 32'd20, 32'd2, 1'b0, 5'd2, 32'd22, 3'b010, 1'b0, 1'b0, 1'b1);
        fork
            send(ALU_ADD, 32'd30, 32'd3, 1'b0, 5'd3, 32'd33, 3'b010, 1'b0, 1'b0, 1'b1);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready_low", 64'(in_ready), 64'd0);
                    chk("stall_out_held", {out_result, 27'd0, out_tag}, {32'd11, 27'd0, 5'd1});
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Test 5: flush with E1, E2 full and a new input
        out_ready = 1'b0;
        send(ALU_ADD, 32'd1, 32'd1, 1'b0, 5'd20, 32'd2, 3'b010, 1'b0, 1'b0, 1'b0);
        send(ALU_ADD, 32'd2, 32'd2, 1'b0, 5'd21, 32'd4, 3'b010, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_flush_full", 64'({out_valid, in_ready}), 64'b10);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_op    = ALU_ADD;
        in_tag   = 5'd22;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_flush_no_output", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Test 6: asynchronous reset mid-stream
        out_ready = 1'b0;
        send(ALU_ADD, 32'd5, 32'd6, 1'b0, 5'd7, 32'd11, 3'b010, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_out_valid", 64'(out_valid), 64'd0);
        chk("async_reset_outputs", {out_result, 21'd0, out_cr, out_ca, out_ov, out_tag}, 64'd0);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;

        // Pipeline works after reset
        send(ALU_SUBF, 32'd1, 32'd1, 1'b0, 5'd30, 32'd0, 3'b001, 1'b1, 1'b0, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
